// File: rtl/bcd_arb_pkg.sv
// Shared types and widths for the BCD converter arbiter.
package bcd_arb_pkg;

   typedef enum logic [1:0] {IDLE, CONVERT, HOLD} bcd_arb_state_t;

   localparam int unsigned BIN_W = 4;
   localparam int unsigned BCD_W = 8;

endpackage

// File: rtl/Binario_a_BCD.sv
// Combinational 4-bit binary to two-digit BCD converter shared by the arbiter.
module Binario_a_BCD
   import bcd_arb_pkg::*;
(
   input  logic [BIN_W-1:0] binario,
   output logic [BCD_W-1:0] bcd
);

   always_comb begin
      bcd = '0;
      if (binario >= 4'd10) begin
         bcd = {4'h1, binario - 4'd10};
      end else begin
         bcd = {4'h0, binario};
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick; the search starts just after last_grant.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             any_req
);

   logic            found;
   logic [ID_W-1:0] idx;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         idx = ID_W'((32'(last_grant) + off) % N_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = idx;
            found      = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sequencer sharing one external binary-to-BCD converter among
// N_REQ requesters, returning tagged results over a valid/ready handshake.
module bcd_conv_arbiter
   import bcd_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [BIN_W*N_REQ-1:0] data_in,
   output logic [N_REQ-1:0]       ack,
   output logic [BIN_W-1:0]       conv_bin,
   input  logic [BCD_W-1:0]       conv_bcd,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [BCD_W-1:0]       result_bcd,
   output logic [ID_W-1:0]        result_id,
   output logic                   busy
);

   bcd_arb_state_t   state;
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  cur_id;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_id;
   logic             any_req;
   logic [BIN_W-1:0] sel_bin;
   logic             take;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_arbiter (
      .req        (req),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_id   (grant_id),
      .any_req    (any_req)
   );

   always_comb begin
      sel_bin = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_bin = data_in[i*BIN_W +: BIN_W];
         end
      end
   end

   // A grant happens from IDLE, or from HOLD in the same cycle the result is accepted.
   assign take = any_req && ((state == IDLE) || ((state == HOLD) && result_ready));
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ack          <= '0;
         conv_bin     <= '0;
         result_valid <= 1'b0;
         result_bcd   <= '0;
         result_id    <= '0;
         cur_id       <= '0;
         last_grant   <= ID_W'(N_REQ - 1);
      end else begin
         ack <= '0;
         if (take) begin
            ack        <= grant;
            conv_bin   <= sel_bin;
            cur_id     <= grant_id;
            last_grant <= grant_id;
         end
         case (state)
            IDLE: begin
               if (any_req) state <= CONVERT;
            end
            CONVERT: begin
               result_bcd   <= conv_bcd;
               result_id    <= cur_id;
               result_valid <= 1'b1;
               state        <= HOLD;
            end
            HOLD: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  state        <= any_req ? CONVERT : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

- Round-robin arbiter and sequencer that shares one `Binario_a_BCD` converter (4-bit binary in, 8-bit two-digit BCD out, combinational) among `N_REQ` requesters.
- Latches the granted requester's operand into the converter, captures the BCD result one cycle later, and returns it with a valid/ready handshake tagged by requester id.
- Sits between the lab's input sources (switch banks, counters) and the display/decoder path.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester id.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req`, in, `N_REQ`: request per requester; held high with stable operand until its `ack`.
- `data_in`, in, `4*N_REQ`: flattened operands; requester i uses bits `[4i+3:4i]`.
- `ack`, out, `N_REQ`: one-cycle, one-hot pulse; the operand is taken.
- `conv_bin`, out, 4: registered operand driven to the shared converter.
- `conv_bcd`, in, 8: converter output.
- `result_valid`, out, 1: `result_bcd`/`result_id` are valid.
- `result_ready`, in, 1: consumer accepts the result.
- `result_bcd`, out, 8: captured BCD; upper nibble is tens, lower nibble is units.
- `result_id`, out, `ID_W`: requester that owns the result.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

- FSM states: IDLE, CONVERT, HOLD.
- **IDLE:** if any `req`, grant per round-robin, load `conv_bin <= data_in[granted]`, pulse `ack[granted]`, go to CONVERT. Otherwise stay.
- **CONVERT:** capture `result_bcd <= conv_bcd`, `result_id <= granted id`, set `result_valid`, go to HOLD.
- **HOLD:** hold `result_valid`, `result_bcd` and `result_id` stable until `result_valid && result_ready`. On that handshake:
  - clear `result_valid`;
  - if any `req` is pending, grant immediately (same actions as IDLE) and go to CONVERT;
  - otherwise go to IDLE.
- **Round-robin:** search starts at `last_grant+1` and wraps modulo `N_REQ`; `last_grant` updates on every grant. Result: a requester held high is served within `N_REQ` grants.
- **Operand range:** operands 10..15 are passed unchanged; the converter yields 8'h10..8'h15. No saturation and no error flag.
- **Request hold/release:**
  - A requester whose `req` stays high after `ack` is re-arbitrated as a new request.
  - A `req` dropped before `ack` is simply not served.
- **Reset values:** state IDLE, `ack`=0, `conv_bin`=4'h0, `result_valid`=0, `result_bcd`=8'h00, `result_id`=0, `busy`=0, `last_grant`=`N_REQ-1` (requester 0 wins first).
- **Reset mid-operation:** any in-flight or held result is discarded and no `result_valid` is issued. Requesters not yet acked must keep requesting.

## Timing

- Edge k samples a winning `req` in IDLE. Then:
  - `ack` and the new `conv_bin` are high/valid during cycle k+1 (state CONVERT);
  - `result_valid` is high from cycle k+2.
- Request-to-result latency: 2 cycles.
- With `result_ready` tied high and requests pending, one result per 2 cycles (HOLD→CONVERT→HOLD).
- `conv_bin` is stable from CONVERT through the end of HOLD. The converter path must settle within one clock.
- `result_ready` low in HOLD stalls indefinitely: no grants, no `ack`, outputs frozen.
- Simultaneous requests: exactly one `ack` bit per grant, never two.
- `busy` is combinational from state.

## Structure

- Package `bcd_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, CONVERT, HOLD} bcd_arb_state_t`;
  - constants `BIN_W=4`, `BCD_W=8`.
- Sub-module `rr_arbiter`: parameterised on `N_REQ`. Inputs `req` and `last_grant`; outputs one-hot grant, grant id and `any_req`. It is combinational, and the pointer register stays in the parent.
- The converter is instantiated by the integrating top level, not inside this block. The bench instantiates `Binario_a_BCD` beside it.

## Test plan

- Single request: `req`=4'b0001, `data_in[3:0]`=4'b1001, `result_ready`=1.
  - Required: `ack`=4'b0001 in cycle 1, `result_valid` with `result_bcd`=8'h09 and `result_id`=0 in cycle 2, back to IDLE in cycle 3.
- All four requesting with operands 4'h3, 4'h7, 4'hA, 4'hF, `req` held and `result_ready`=1.
  - Required: results in id order 0,1,2,3,0…, with `result_bcd` 8'h03, 8'h07, 8'h10, 8'h15, one every 2 cycles.
- Backpressure: `result_ready`=0 for 5 cycles in HOLD with `req`=4'b0110 pending.
  - Required: `result_valid`, `result_bcd` and `result_id` are frozen and no `ack` during the stall.
  - Required: on `ready`=1, the next grant goes to id 2 if `last_grant`=1.
- Wrap-around: `last_grant`=3, `req`=4'b1001.
  - Required: grant to 0, then to 3, then to 0.
- Reset during CONVERT with `data_in`=4'hD.
  - Required: next cycle all outputs are at reset values and `result_valid` stays 0.
  - Required: the first grant after release goes to requester 0.
- Boundary operands 4'h0 and 4'hF.
  - Required: 8'h00 and 8'h15; `busy` low only while in IDLE.
